// File: rtl/broadcast_probe_issuer.sv
// broadcast_probe_issuer: takes one filtered request at a time, probes every
// client in index order, collects acks in a pending mask, then reports done.
//
// Ports:
//   clock, reset             rising-edge clock, synchronous active-low reset
//   io_filter_*              request in (ready/valid): mshr, address, allocOH, needT
//   io_probe_*               probe out (ready/valid): client, address, param
//   io_ack_*                 probe ack in (valid only, always accepted)
//   io_done_*                completion out (ready/valid): mshr, allocOH
module broadcast_probe_issuer #(
    parameter int NUM_CLIENTS = 4,
    parameter int MSHR_BITS   = 2,
    parameter int ADDR_BITS   = 32,
    localparam int CLIENT_BITS =
        (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_filter_ready,
    input  logic                   io_filter_valid,
    input  logic [MSHR_BITS-1:0]   io_filter_bits_mshr,
    input  logic [ADDR_BITS-1:0]   io_filter_bits_address,
    input  logic                   io_filter_bits_allocOH,
    input  logic                   io_filter_bits_needT,
    input  logic                   io_probe_ready,
    output logic                   io_probe_valid,
    output logic [CLIENT_BITS-1:0] io_probe_bits_client,
    output logic [ADDR_BITS-1:0]   io_probe_bits_address,
    output logic [1:0]             io_probe_bits_param,
    input  logic                   io_ack_valid,
    input  logic [CLIENT_BITS-1:0] io_ack_bits_client,
    input  logic                   io_done_ready,
    output logic                   io_done_valid,
    output logic [MSHR_BITS-1:0]   io_done_bits_mshr,
    output logic                   io_done_bits_allocOH
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CLIENT_BITS-1:0] LAST_IDX =
        CLIENT_BITS'(NUM_CLIENTS - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_CLIENTS-1:0] r_pending;
    logic [NUM_CLIENTS-1:0] w_pending_set;
    logic [NUM_CLIENTS-1:0] w_pending_clr;
    logic [NUM_CLIENTS-1:0] w_pending_nxt;
    logic [CLIENT_BITS-1:0] r_probe_idx;
    logic [MSHR_BITS-1:0]   r_mshr;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_alloc;
    logic                   r_needt;

    logic w_filter_fire;
    logic w_probe_fire;
    logic w_done_fire;
    logic w_last_probe;

    assign w_filter_fire = io_filter_valid & io_filter_ready;
    assign w_probe_fire  = io_probe_valid & io_probe_ready;
    assign w_done_fire   = io_done_valid & io_done_ready;
    assign w_last_probe  = (r_probe_idx == LAST_IDX);

    // Clearing a bit that is not pending is a no-op, which is how stray,
    // duplicate and out-of-range acks are ignored. The set term wins, so an
    // ack arriving with the probe to that same client does not count.
    always_comb begin
        w_pending_set = '0;
        w_pending_clr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_probe_fire && (r_probe_idx == CLIENT_BITS'(i)))
                w_pending_set[i] = 1'b1;
            if (io_ack_valid && (io_ack_bits_client == CLIENT_BITS'(i)))
                w_pending_clr[i] = 1'b1;
        end
        w_pending_nxt = (r_pending & ~w_pending_clr) | w_pending_set;
    end

    // State register
    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; WAIT looks at the mask after this cycle's ack
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_filter_fire) w_state_nxt = S_PROBE;
            S_PROBE: if (w_probe_fire && w_last_probe) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_pending_nxt == '0) w_state_nxt = S_DONE;
            S_DONE:  if (w_done_fire) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        io_filter_ready = 1'b0;
        io_probe_valid  = 1'b0;
        io_done_valid   = 1'b0;
        unique case (r_state)
            S_IDLE:  io_filter_ready = 1'b1;
            S_PROBE: io_probe_valid  = 1'b1;
            S_WAIT:  ;
            S_DONE:  io_done_valid   = 1'b1;
            default: ;
        endcase
    end

    assign io_probe_bits_client  = r_probe_idx;
    assign io_probe_bits_address = r_addr;
    assign io_probe_bits_param   = r_needt ? 2'd2 : 2'd1;
    assign io_done_bits_mshr     = r_mshr;
    assign io_done_bits_allocOH  = r_alloc;

    // Datapath: latched request, probe index, pending mask
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pending   <= '0;
            r_probe_idx <= '0;
            r_mshr      <= '0;
            r_addr      <= '0;
            r_alloc     <= 1'b0;
            r_needt     <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_filter_fire) begin
                r_probe_idx <= '0;
                r_mshr      <= io_filter_bits_mshr;
                r_addr      <= io_filter_bits_address;
                r_alloc     <= io_filter_bits_allocOH;
                r_needt     <= io_filter_bits_needT;
            end else if (w_probe_fire && !w_last_probe) begin
                r_probe_idx <= r_probe_idx + CLIENT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_broadcast_probe_issuer.sv
// tb_broadcast_probe_issuer: directed vectors for broadcast_probe_issuer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_broadcast_probe_issuer;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_filter_ready;
    logic        io_filter_valid;
    logic [1:0]  io_filter_bits_mshr;
    logic [31:0] io_filter_bits_address;
    logic        io_filter_bits_allocOH;
    logic        io_filter_bits_needT;
    logic        io_probe_ready;
    logic        io_probe_valid;
    logic [1:0]  io_probe_bits_client;
    logic [31:0] io_probe_bits_address;
    logic [1:0]  io_probe_bits_param;
    logic        io_ack_valid;
    logic [1:0]  io_ack_bits_client;
    logic        io_done_ready;
    logic        io_done_valid;
    logic [1:0]  io_done_bits_mshr;
    logic        io_done_bits_allocOH;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    broadcast_probe_issuer #(
        .NUM_CLIENTS(4),
        .MSHR_BITS  (2),
        .ADDR_BITS  (32)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_filter_ready       (io_filter_ready),
        .io_filter_valid       (io_filter_valid),
        .io_filter_bits_mshr   (io_filter_bits_mshr),
        .io_filter_bits_address(io_filter_bits_address),
        .io_filter_bits_allocOH(io_filter_bits_allocOH),
        .io_filter_bits_needT  (io_filter_bits_needT),
        .io_probe_ready        (io_probe_ready),
        .io_probe_valid        (io_probe_valid),
        .io_probe_bits_client  (io_probe_bits_client),
        .io_probe_bits_address (io_probe_bits_address),
        .io_probe_bits_param   (io_probe_bits_param),
        .io_ack_valid          (io_ack_valid),
        .io_ack_bits_client    (io_ack_bits_client),
        .io_done_ready         (io_done_ready),
        .io_done_valid         (io_done_valid),
        .io_done_bits_mshr     (io_done_bits_mshr),
        .io_done_bits_allocOH  (io_done_bits_allocOH)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic issue(input logic [1:0] m, input logic [31:0] a,
                         input logic al, input logic nt);
        io_filter_valid        = 1'b1;
        io_filter_bits_mshr    = m;
        io_filter_bits_address = a;
        io_filter_bits_allocOH = al;
        io_filter_bits_needT   = nt;
        chk("filter_ready", 64'(io_filter_ready), 64'd1);
        step();
        io_filter_valid = 1'b0;
    endtask

    // Expected client only advances on a cycle where ready was offered
    task automatic probe_all(input logic [1:0] prm, input logic [31:0] a,
                             input bit stall);
        int exp_c = 0;
        int cyc   = 0;
        while (exp_c < 4 && cyc < 16) begin
            io_probe_ready = stall ? ((cyc % 2) == 0) : 1'b1;
            chk("probe_valid", 64'(io_probe_valid), 64'd1);
            chk("probe_client", 64'(io_probe_bits_client), 64'(exp_c));
            chk("probe_param", 64'(io_probe_bits_param), 64'(prm));
            chk("probe_addr", 64'(io_probe_bits_address), 64'(a));
            if (io_probe_ready) exp_c++;
            cyc++;
            step();
        end
        io_probe_ready = 1'b0;
        chk("probe_count", 64'(exp_c), 64'd4);
        chk("probe_after_last", 64'(io_probe_valid), 64'd0);
    endtask

    task automatic ack(input logic [1:0] c);
        io_ack_valid       = 1'b1;
        io_ack_bits_client = c;
        step();
        io_ack_valid = 1'b0;
    endtask

    task automatic take_done(input logic [1:0] m, input logic al);
        chk("done_valid", 64'(io_done_valid), 64'd1);
        chk("done_mshr", 64'(io_done_bits_mshr), 64'(m));
        chk("done_alloc", 64'(io_done_bits_allocOH), 64'(al));
        chk("filter_busy", 64'(io_filter_ready), 64'd0);
        io_done_ready = 1'b1;
        step();
        io_done_ready = 1'b0;
        chk("idle_ready", 64'(io_filter_ready), 64'd1);
        chk("idle_done", 64'(io_done_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                  = 1'b0;
        io_filter_valid        = 1'b0;
        io_filter_bits_mshr    = '0;
        io_filter_bits_address = '0;
        io_filter_bits_allocOH = 1'b0;
        io_filter_bits_needT   = 1'b0;
        io_probe_ready         = 1'b0;
        io_ack_valid           = 1'b0;
        io_ack_bits_client     = '0;
        io_done_ready          = 1'b0;
        repeat (3) step();
        chk("rst_filter_ready", 64'(io_filter_ready), 64'd1);
        chk("rst_probe_valid", 64'(io_probe_valid), 64'd0);
        chk("rst_done_valid", 64'(io_done_valid), 64'd0);
        reset = 1'b1;
        step();

        // 1: back-to-back probes, ack one cycle behind each probe
        issue(2'd2, 32'h8000_0040, 1'b1, 1'b1);
        io_probe_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t1_probe_valid", 64'(io_probe_valid), 64'd1);
            chk("t1_client", 64'(io_probe_bits_client), 64'(k));
            chk("t1_param", 64'(io_probe_bits_param), 64'd2);
            chk("t1_addr", 64'(io_probe_bits_address), 64'h8000_0040);
            io_ack_valid       = (k > 0);
            io_ack_bits_client = 2'(k - 1);
            step();
        end
        io_probe_ready = 1'b0;
        chk("t1_wait_probe", 64'(io_probe_valid), 64'd0);
        chk("t1_wait_done", 64'(io_done_valid), 64'd0);
        ack(2'd3);
        take_done(2'd2, 1'b1);

        // 2: downgrade with probe_ready toggling
        issue(2'd1, 32'h0000_1000, 1'b0, 1'b0);
        probe_all(2'd1, 32'h0000_1000, 1'b1);
        for (int c = 0; c < 4; c++) ack(2'(c));
        take_done(2'd1, 1'b0);

        // 3: out-of-order acks, client 1 late
        issue(2'd3, 32'hDEAD_BEC0, 1'b1, 1'b1);
        probe_all(2'd2, 32'hDEAD_BEC0, 1'b0);
        ack(2'd3);
        ack(2'd0);
        ack(2'd2);
        repeat (5) begin
            chk("t3_done_early", 64'(io_done_valid), 64'd0);
            step();
        end
        ack(2'd1);
        take_done(2'd3, 1'b1);

        // 4: ack in IDLE and duplicate ack are ignored
        ack(2'd0);
        issue(2'd0, 32'h0000_0080, 1'b1, 1'b0);
        probe_all(2'd1, 32'h0000_0080, 1'b0);
        ack(2'd0);
        ack(2'd0);
        ack(2'd1);
        ack(2'd2);
        chk("t4_done_early", 64'(io_done_valid), 64'd0);
        ack(2'd3);
        chk("t4_done_valid", 64'(io_done_valid), 64'd1);
        chk("t4_done_mshr", 64'(io_done_bits_mshr), 64'd0);

        // 5: done held under back-pressure, no same-cycle accept
        io_filter_valid        = 1'b1;
        io_filter_bits_mshr    = 2'd1;
        io_filter_bits_address = 32'h1234_5678;
        io_filter_bits_allocOH = 1'b0;
        io_filter_bits_needT   = 1'b1;
        repeat (3) begin
            chk("t5_done_held", 64'(io_done_valid), 64'd1);
            chk("t5_filter_low", 64'(io_filter_ready), 64'd0);
            step();
        end
        io_done_ready = 1'b1;
        chk("t5_done_fire", 64'(io_done_valid), 64'd1);
        chk("t5_no_bypass", 64'(io_filter_ready), 64'd0);
        step();
        io_done_ready = 1'b0;
        chk("t5_idle_ready", 64'(io_filter_ready), 64'd1);
        chk("t5_idle_done", 64'(io_done_valid), 64'd0);
        step();
        io_filter_valid = 1'b0;
        probe_all(2'd2, 32'h1234_5678, 1'b0);

        // 6: reset in WAIT with two acks outstanding
        ack(2'd0);
        ack(2'd1);
        chk("t6_wait_done", 64'(io_done_valid), 64'd0);
        reset = 1'b0;
        step();
        chk("t6_filter_ready", 64'(io_filter_ready), 64'd1);
        chk("t6_probe_valid", 64'(io_probe_valid), 64'd0);
        chk("t6_done_valid", 64'(io_done_valid), 64'd0);
        reset = 1'b1;
        step();
        chk("t6_post_done", 64'(io_done_valid), 64'd0);
        chk("t6_post_ready", 64'(io_filter_ready), 64'd1);
        issue(2'd2, 32'hFFFF_FFC0, 1'b0, 1'b0);
        probe_all(2'd1, 32'hFFFF_FFC0, 1'b0);
        for (int c = 3; c >= 0; c--) ack(2'(c));
        take_done(2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
